// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and the coordinate type used by all draw stages.
package vga_pkg;

  // Pixel coordinate as seen by draw stages (DrawX/DrawY and their ROM address maths).
  typedef logic [9:0] coord_t;

  // 640x480 @ 60 Hz timing defaults.
  localparam int unsigned H_VIS_DEF  = 640;
  localparam int unsigned H_FP_DEF   = 16;
  localparam int unsigned H_SYNC_DEF = 96;
  localparam int unsigned H_BP_DEF   = 48;
  localparam int unsigned V_VIS_DEF  = 480;
  localparam int unsigned V_FP_DEF   = 10;
  localparam int unsigned V_SYNC_DEF = 2;
  localparam int unsigned V_BP_DEF   = 33;

  // Derived totals and sync window for the default timing.
  localparam int unsigned H_TOT_DEF        = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOT_DEF        = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int unsigned H_SYNC_START_DEF = H_VIS_DEF + H_FP_DEF;
  localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int unsigned V_SYNC_START_DEF = V_VIS_DEF + V_FP_DEF;
  localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  // Narrow an elaboration-time count to a coordinate.
  function automatic coord_t to_coord(input int unsigned value);
    return coord_t'(value);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Shift register for sync signals; resets to 1 (sync inactive). Depth 0 is a pass-through.
module sync_delay #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Depth == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign q_o = d_i;
  end else begin : g_delay
    logic [Width-1:0] stage_q [Depth];

    // Shift raw sync through Depth stages; reset forces every stage inactive.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < Depth; i++) begin
          stage_q[i] <= '1;
        end
      end else begin
        stage_q[0] <= d_i;
        for (int unsigned i = 1; i < Depth; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, visible flag, delayed active-low syncs, start pulses.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VIS      = H_VIS_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_VIS      = V_VIS_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  output coord_t     DrawX,
  output coord_t     DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       line_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam coord_t HLast       = to_coord(H_TOT - 1);
  localparam coord_t VLast       = to_coord(V_TOT - 1);
  localparam coord_t HVisC       = to_coord(H_VIS);
  localparam coord_t VVisC       = to_coord(V_VIS);
  localparam coord_t HSyncStart  = to_coord(H_VIS + H_FP);
  localparam coord_t HSyncEnd    = to_coord(H_VIS + H_FP + H_SYNC);
  localparam coord_t VSyncStart  = to_coord(V_VIS + V_FP);
  localparam coord_t VSyncEnd    = to_coord(V_VIS + V_FP + V_SYNC);

  coord_t     hc_q, hc_d, vc_q, vc_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       line_start_q, frame_start_q;
  logic       line_end, frame_end;
  logic       hs_raw, vs_raw;
  logic [1:0] sync_dly;

  assign line_end  = (hc_q == HLast);
  assign frame_end = line_end && (vc_q == VLast);

  // Next-state for the raster counters and the frame counter.
  always_comb begin
    hc_d          = line_end ? '0 : hc_q + coord_t'(1);
    vc_d          = vc_q;
    frame_count_d = frame_count_q;
    if (line_end) begin
      vc_d = (vc_q == VLast) ? '0 : vc_q + coord_t'(1);
    end
    if (frame_end) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  // Counter and pulse registers; pulses land in the cycle the counters sit at the wrap target.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc_q          <= '0;
      vc_q          <= '0;
      frame_count_q <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      frame_count_q <= frame_count_d;
      line_start_q  <= line_end;
      frame_start_q <= frame_end;
    end
  end

  // Visible flag and raw syncs decoded straight from the counter registers.
  always_comb begin
    blank  = (hc_q < HVisC) && (vc_q < VVisC);
    hs_raw = !((hc_q >= HSyncStart) && (hc_q < HSyncEnd));
    vs_raw = !((vc_q >= VSyncStart) && (vc_q < VSyncEnd));
  end

  // Delay syncs to match the draw-stage pipeline so they line up with RGB at the DAC.
  sync_delay #(
    .Depth(SYNC_DELAY),
    .Width(2)
  ) u_sync_delay (
    .clk_i(vga_clk),
    .rst_i(reset),
    .d_i  ({hs_raw, vs_raw}),
    .q_o  (sync_dly)
  );

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign hs          = sync_dly[1];
  assign vs          = sync_dly[0];
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default timing with SYNC_DELAY 0/1/3, plus a reduced 16x8 build for frame tests.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic vga_clk;
  logic reset;

  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  coord_t d1_x, d1_y, d0_x, d0_y, d3_x, d3_y, s_x, s_y;
  logic d1_blank, d1_hs, d1_vs, d1_fs, d1_ls;
  logic d0_blank, d0_hs, d0_vs, d0_fs, d0_ls;
  logic d3_blank, d3_hs, d3_vs, d3_fs, d3_ls;
  logic s_blank, s_hs, s_vs, s_fs, s_ls;
  logic [7:0] d1_fc, d0_fc, d3_fc, s_fc;

  int checks = 0;
  int errors = 0;

  vga_timing_gen #(.SYNC_DELAY(1)) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(d1_x), .DrawY(d1_y), .blank(d1_blank),
    .hs(d1_hs), .vs(d1_vs), .frame_start(d1_fs), .line_start(d1_ls), .frame_count(d1_fc)
  );

  vga_timing_gen #(.SYNC_DELAY(0)) dut_d0 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(d0_x), .DrawY(d0_y), .blank(d0_blank),
    .hs(d0_hs), .vs(d0_vs), .frame_start(d0_fs), .line_start(d0_ls), .frame_count(d0_fc)
  );

  vga_timing_gen #(.SYNC_DELAY(3)) dut_d3 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(d3_x), .DrawY(d3_y), .blank(d3_blank),
    .hs(d3_hs), .vs(d3_vs), .frame_start(d3_fs), .line_start(d3_ls), .frame_count(d3_fc)
  );

  // Reduced raster: H_TOT=16 (hs raw low 10..12), V_TOT=8 (vs raw low 5..6), 128 cycles/frame.
  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(1)
  ) dut_s (
    .vga_clk(vga_clk), .reset(reset), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
    .hs(s_hs), .vs(s_vs), .frame_start(s_fs), .line_start(s_ls), .frame_count(s_fc)
  );

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  // Leaves every DUT at (0,0) with reset just deasserted.
  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(2);
    repeat (300) tick();
    checks++; if (d1_x !== coord_t'(300)) begin errors++;
      $display("FAIL rst_pre_x got=%0d exp=300", d1_x); end
    checks++; if (s_x !== coord_t'(12) || s_y !== coord_t'(2)) begin errors++;
      $display("FAIL rst_pre_small got=(%0d,%0d) exp=(12,2)", s_x, s_y); end
    checks++; if (s_hs !== 1'b0) begin errors++;
      $display("FAIL rst_pre_small_hs got=%b exp=0", s_hs); end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (d1_x !== '0 || d1_y !== '0 || d1_blank !== 1'b1) begin errors++;
        $display("FAIL rst_coord cyc=%0d got=(%0d,%0d,%b) exp=(0,0,1)", i, d1_x, d1_y, d1_blank); end
      checks++; if (d1_hs !== 1'b1 || d1_vs !== 1'b1 || s_hs !== 1'b1 || s_vs !== 1'b1) begin
        errors++; $display("FAIL rst_sync cyc=%0d got=%b%b%b%b exp=1111", i, d1_hs, d1_vs,
                           s_hs, s_vs); end
      checks++; if (d1_fc !== 8'd0 || d1_fs !== 1'b0 || d1_ls !== 1'b0) begin errors++;
        $display("FAIL rst_pulses cyc=%0d got fc=%0d fs=%b ls=%b exp 0", i, d1_fc, d1_fs, d1_ls); end
      checks++; if (s_x !== '0 || s_y !== '0) begin errors++;
        $display("FAIL rst_small cyc=%0d got=(%0d,%0d) exp=(0,0)", i, s_x, s_y); end
    end
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (d1_x !== coord_t'(i)) begin errors++;
        $display("FAIL rst_release_x got=%0d exp=%0d", d1_x, i); end
    end
    // Reset while delay stages hold an active sync pulse: stages must be forced inactive.
    apply_reset(1);
    repeat (658) tick();
    checks++; if (d1_hs !== 1'b0) begin errors++;
      $display("FAIL rst_pre_hs got=%b exp=0", d1_hs); end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (d3_hs !== 1'b1 || d1_hs !== 1'b1 || d0_hs !== 1'b1) begin errors++;
        $display("FAIL rst_hs_flush cyc=%0d got d0=%b d1=%b d3=%b exp=1", i, d0_hs, d1_hs, d3_hs); end
    end
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (d3_hs !== 1'b1 || d3_x !== coord_t'(i)) begin errors++;
        $display("FAIL rst_hs_after got hs=%b x=%0d exp hs=1 x=%0d", d3_hs, d3_x, i); end
    end
  endtask

  task automatic test_horizontal();
    int hc, vc, ls_cnt;
    logic e_blank, e_hs0, e_hs1, e_hs3;
    hc = 0; vc = 0; ls_cnt = 0;
    apply_reset(1);
    for (int i = 0; i < 1600; i++) begin
      tick();
      hc++;
      if (hc == 800) begin hc = 0; vc++; end
      e_blank = (hc < 640);
      e_hs0   = !(hc >= 656 && hc <= 751);
      e_hs1   = !(hc >= 657 && hc <= 752);
      e_hs3   = !(hc >= 659 && hc <= 754);
      checks++; if (d1_x !== coord_t'(hc) || d1_y !== coord_t'(vc)) begin errors++;
        $display("FAIL h_coord got=(%0d,%0d) exp=(%0d,%0d)", d1_x, d1_y, hc, vc); end
      checks++; if (d0_x !== coord_t'(hc) || d3_x !== coord_t'(hc)) begin errors++;
        $display("FAIL h_coord_sweep got d0=%0d d3=%0d exp=%0d", d0_x, d3_x, hc); end
      checks++; if (d1_blank !== e_blank || d0_blank !== e_blank || d3_blank !== e_blank) begin
        errors++; $display("FAIL h_blank hc=%0d got=%b%b%b exp=%b", hc, d0_blank, d1_blank,
                           d3_blank, e_blank); end
      checks++; if (d1_hs !== e_hs1) begin errors++;
        $display("FAIL h_hs1 hc=%0d got=%b exp=%b", hc, d1_hs, e_hs1); end
      checks++; if (d0_hs !== e_hs0) begin errors++;
        $display("FAIL h_hs0 hc=%0d got=%b exp=%b", hc, d0_hs, e_hs0); end
      checks++; if (d3_hs !== e_hs3) begin errors++;
        $display("FAIL h_hs3 hc=%0d got=%b exp=%b", hc, d3_hs, e_hs3); end
      checks++; if (d1_vs !== 1'b1) begin errors++;
        $display("FAIL h_vs hc=%0d got=%b exp=1", hc, d1_vs); end
      checks++; if (d1_ls !== logic'(hc == 0)) begin errors++;
        $display("FAIL h_line_start hc=%0d got=%b exp=%b", hc, d1_ls, hc == 0); end
      if (d1_ls === 1'b1) ls_cnt++;
    end
    checks++; if (ls_cnt != 2) begin errors++;
      $display("FAIL h_line_start_count got=%0d exp=2", ls_cnt); end
  endtask

  task automatic test_sync_delay();
    int hc, f0, f1, f3, low1;
    hc = 0; f0 = -1; f1 = -1; f3 = -1; low1 = 0;
    apply_reset(1);
    for (int i = 0; i < 799; i++) begin
      tick();
      hc++;
      if (d0_hs === 1'b0 && f0 < 0) f0 = hc;
      if (d1_hs === 1'b0 && f1 < 0) f1 = hc;
      if (d3_hs === 1'b0 && f3 < 0) f3 = hc;
      if (d1_hs === 1'b0) low1++;
    end
    checks++; if (f0 != 656) begin errors++; $display("FAIL sd_fall0 got=%0d exp=656", f0); end
    checks++; if (f1 != 657) begin errors++; $display("FAIL sd_fall1 got=%0d exp=657", f1); end
    checks++; if (f3 != 659) begin errors++; $display("FAIL sd_fall3 got=%0d exp=659", f3); end
    checks++; if (low1 != 96) begin errors++; $display("FAIL sd_hs_width got=%0d exp=96", low1); end
  endtask

  task automatic test_vertical();
    int hc, vc, vs_low, first_hc, first_vc;
    logic raw_vs, raw_hs;
    hc = 0; vc = 0; vs_low = 0; first_hc = -1; first_vc = -1;
    apply_reset(1);
    for (int i = 0; i < 128; i++) begin
      raw_vs = !(vc >= 5 && vc <= 6);
      raw_hs = !(hc >= 10 && hc <= 12);
      tick();
      hc++;
      if (hc == 16) begin hc = 0; vc = (vc + 1) % 8; end
      checks++; if (s_x !== coord_t'(hc) || s_y !== coord_t'(vc)) begin errors++;
        $display("FAIL v_coord got=(%0d,%0d) exp=(%0d,%0d)", s_x, s_y, hc, vc); end
      checks++; if (s_blank !== logic'(hc < 8 && vc < 4)) begin errors++;
        $display("FAIL v_blank (%0d,%0d) got=%b exp=%b", hc, vc, s_blank, hc < 8 && vc < 4); end
      checks++; if (s_vs !== raw_vs || s_hs !== raw_hs) begin errors++;
        $display("FAIL v_sync (%0d,%0d) got hs=%b vs=%b exp hs=%b vs=%b", hc, vc, s_hs, s_vs,
                 raw_hs, raw_vs); end
      if (s_vs === 1'b0) begin
        vs_low++;
        if (first_hc < 0) begin first_hc = hc; first_vc = vc; end
      end
    end
    checks++; if (vs_low != 32) begin errors++;
      $display("FAIL v_vs_width got=%0d exp=32", vs_low); end
    checks++; if (first_hc != 1 || first_vc != 5) begin errors++;
      $display("FAIL v_vs_start got=(%0d,%0d) exp=(1,5)", first_hc, first_vc); end
  endtask

  task automatic test_frame_wrap();
    int hc, vc, frames, fs_cnt;
    logic wrap;
    hc = 0; vc = 0; frames = 0; fs_cnt = 0;
    apply_reset(1);
    for (int i = 0; i < 384; i++) begin
      wrap = (hc == 15 && vc == 7);
      tick();
      hc++;
      if (hc == 16) begin hc = 0; vc = (vc + 1) % 8; end
      if (wrap) frames++;
      checks++; if (s_fs !== wrap) begin errors++;
        $display("FAIL fw_frame_start (%0d,%0d) got=%b exp=%b", hc, vc, s_fs, wrap); end
      checks++; if (s_fc !== 8'(frames)) begin errors++;
        $display("FAIL fw_frame_count got=%0d exp=%0d", s_fc, frames); end
      checks++; if (s_ls !== logic'(hc == 0)) begin errors++;
        $display("FAIL fw_line_start hc=%0d got=%b exp=%b", hc, s_ls, hc == 0); end
      if (wrap) begin
        checks++; if (s_x !== '0 || s_y !== '0) begin errors++;
          $display("FAIL fw_wrap_pos got=(%0d,%0d) exp=(0,0)", s_x, s_y); end
      end
      checks++; if (d1_fs !== 1'b0) begin errors++;
        $display("FAIL fw_no_early_fs cyc=%0d got=%b exp=0", i, d1_fs); end
      if (s_fs === 1'b1) fs_cnt++;
    end
    checks++; if (fs_cnt != 3) begin errors++;
      $display("FAIL fw_fs_count got=%0d exp=3", fs_cnt); end
  endtask

  task automatic test_fc_wrap();
    int cyc, last_hs, last_vs;
    logic prev_hs, prev_vs;
    cyc = 0; last_hs = -1; last_vs = -1; prev_hs = 1'b1; prev_vs = 1'b1;
    apply_reset(1);
    for (int f = 0; f < 256; f++) begin
      for (int t = 0; t < 128; t++) begin
        tick();
        cyc++;
        if (prev_hs === 1'b1 && s_hs === 1'b0) begin
          if (last_hs >= 0) begin
            checks++; if (cyc - last_hs != 16) begin errors++;
              $display("FAIL fc_hs_period got=%0d exp=16", cyc - last_hs); end
          end
          last_hs = cyc;
        end
        if (prev_vs === 1'b1 && s_vs === 1'b0) begin
          if (last_vs >= 0) begin
            checks++; if (cyc - last_vs != 128) begin errors++;
              $display("FAIL fc_vs_period got=%0d exp=128", cyc - last_vs); end
          end
          last_vs = cyc;
        end
        prev_hs = s_hs;
        prev_vs = s_vs;
      end
      checks++; if (s_fs !== 1'b1 || s_fc !== 8'(f + 1)) begin errors++;
        $display("FAIL fc_count frame=%0d got fs=%b fc=%0d exp fs=1 fc=%0d", f, s_fs, s_fc,
                 (f + 1) % 256); end
    end
    checks++; if (s_fc !== 8'd0) begin errors++;
      $display("FAIL fc_wrap got=%0d exp=0", s_fc); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_horizontal();
    test_sync_delay();
    test_vertical();
    test_frame_wrap();
    test_fc_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing for the sprite draw stages: pixel coordinates DrawX/DrawY, the visible-area flag `blank`, and active-low hs/vs.
- Sits directly upstream of every draw stage (brick, tank, tile renderers). Its coordinates drive their ROM address maths.
- Draw stages add one cycle of latency from coordinates to RGB (ROM read on negedge, RGB registered on posedge). hs/vs are therefore delayed by a parameterised amount so sync stays aligned with pixel data at the DAC.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_DELAY, 1, register stages applied to hs/vs (0..4)

Ports:
- vga_clk  in  1  pixel clock (25.175 MHz nominal); all logic on posedge
- reset  in  1  synchronous, active-high
- DrawX  out  10  current pixel column (0..H_TOT-1)
- DrawY  out  10  current line (0..V_TOT-1)
- blank  out  1  1 = visible pixel (DrawX<H_VIS and DrawY<V_VIS); draw stages output RGB only when 1
- hs  out  1  horizontal sync, active low, delayed SYNC_DELAY cycles
- vs  out  1  vertical sync, active low, delayed SYNC_DELAY cycles
- frame_start  out  1  one-cycle pulse while counters are at (0,0) following a frame wrap
- line_start  out  1  one-cycle pulse while hc==0 following a line wrap
- frame_count  out  8  frames completed since reset, wraps 255->0

Behaviour:
- Clock and reset: one clock, vga_clk. Reset is synchronous and active-high (`reset`), sampled on posedge vga_clk.
- Totals: H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800). V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525).
- Counters hc and vc, 10 bits each. hc increments every cycle. At hc==H_TOT-1, hc goes to 0 and vc increments. At vc==V_TOT-1 while hc==H_TOT-1, vc goes to 0.
- DrawX=hc and DrawY=vc with zero latency.
- `blank` is combinational from the hc/vc registers, glitch-free: both are registers and the compare is clean.
- Raw sync:
  - hs_raw = 0 iff H_VIS+H_FP <= hc < H_VIS+H_FP+H_SYNC (656..751).
  - vs_raw = 0 iff V_VIS+V_FP <= vc < V_VIS+V_FP+V_SYNC (490..491).
- hs/vs output: raw sync passed through a SYNC_DELAY-deep shift register. With SYNC_DELAY=0 it is a direct combinational pass.
- line_start: registered, asserted in the cycle after hc==H_TOT-1 (i.e. while hc==0).
- frame_start: registered, asserted in the cycle after hc==H_TOT-1 and vc==V_TOT-1 (i.e. while hc==0, vc==0).
- frame_count increments in the same cycle frame_start asserts.
- Reset values (held for the full duration of reset):
  - hc=0, vc=0, so DrawX=0, DrawY=0 and blank=1 (combinational).
  - Every sync delay stage is 1, so hs=1 and vs=1.
  - frame_start=0, line_start=0, frame_count=0.
- First cycle after reset deasserts: counters at (0,0) → (1,0). No frame_start pulse for the reset frame. The first frame_start occurs after the first full wrap, 420000 cycles later.
- Reset mid-frame: all state returns to the reset values on the next posedge. Delayed sync stages are forced to 1 (inactive), so no truncated sync pulse is emitted after reset.
- Wrap-around:
  - hc never exceeds H_TOT-1; vc never exceeds V_TOT-1.
  - frame_count wrap 255->0 is silent (no flag).

Decomposition:
- Package vga_pkg holds:
  - timing defaults (H_VIS..V_BP), derived H_TOT/V_TOT and sync start/end constants;
  - the coordinate typedef `coord_t` (logic [9:0]), shared with draw stages for DrawX/DrawY.
- One sub-module, sync_delay: parameterised DEPTH shift register, reset value 1, with DEPTH=0 as a pass-through. It is instantiated once, carrying hs and vs as a 2-bit bus.

Test Plan:
- Reset behaviour: hold reset 5 cycles mid-frame (hc=300, vc=200) → next posedge DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_count=0. After release, DrawX counts 1,2,3…
- Horizontal timing: run one line → blank is 1 for hc 0..639 and 0 for 640..799. hs (SYNC_DELAY=1) is low exactly during cycles where hc is 657..752 (96 cycles). line_start pulses once per 800 cycles.
- Vertical timing: run one full frame → vs is low for exactly 1600 cycles (2 lines) starting 1 cycle after vc becomes 490, hc=0. blank is 0 for every hc when vc >= 480.
- Frame wrap: observe hc=799, vc=524 → next cycle DrawX=0, DrawY=0, frame_start=1 for exactly 1 cycle, frame_count increments. No frame_start in the first 419999 cycles after reset.
- frame_count wrap: run 256 frames (or force via a reduced-parameter build, e.g. H_VIS=8, V_VIS=4, small porches) → frame_count 255->0, with hs/vs periods equal to the reduced H_TOT/V_TOT.
- SYNC_DELAY sweep: with SYNC_DELAY=0 and then 3, hs falls at hc=656 and hc=659 respectively. DrawX/blank timing is unchanged in both builds.
